// File: rtl/paced_source_if.sv
// rtl/paced_source_if.sv - dti valid/ready stream interface used by paced_source
interface dti #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport producer (output data, output valid, input ready);
  modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/paced_source.sv
// rtl/paced_source.sv - rate-regulated dti transmitter emitting one token per PERIOD cycles
module paced_source #(
  parameter int          PERIOD     = 4,
  parameter bit          REPEAT     = 1'b1,
  parameter logic [63:0] INIT       = 64'd0,
  parameter bit          INIT_VALID = 1'b0
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din,
  dti.producer dout,
  output logic overrun
);

  localparam int            W    = $bits(din.data);
  localparam int            CW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_data;
  logic          r_have;
  logic          r_fresh;
  logic          r_pending;

  logic w_tick;
  logic w_accept;
  logic w_eligible;
  logic w_load;
  logic w_handshake;

  // The register can only take new data while no token is waiting, which also
  // keeps dout.data stable for the whole life of a token.
  assign din.ready   = !r_pending;
  assign w_accept    = din.valid && !r_pending;
  assign w_tick      = (r_cnt == LAST);
  // Data arriving in the tick cycle itself joins that tick's token.
  assign w_eligible  = r_fresh || w_accept || (REPEAT && r_have);
  assign w_load      = w_tick && w_eligible && !r_pending;
  assign w_handshake = r_pending && dout.ready;

  assign dout.valid  = r_pending;
  assign dout.data   = r_data;

  // A tick that finds a token still outstanding is dropped, flagged only if it
  // had something to send.
  assign overrun     = w_tick && r_pending && w_eligible;

  // Free-running tick counter; never stalled by backpressure, so no phase slip.
  always_ff @(posedge clk) begin
    if (rst || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Data register and held/fresh flags; a load consumes fresh data, including
  // data accepted in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= INIT[W-1:0];
      r_have  <= INIT_VALID;
      r_fresh <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data  <= din.data;
        r_have  <= 1'b1;
        r_fresh <= 1'b1;
      end
      if (w_load) begin
        r_fresh <= 1'b0;
      end
    end
  end

  // Outstanding-token flag: set by a load, cleared only by a handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= 1'b0;
    end else if (w_load) begin
      r_pending <= 1'b1;
    end else if (w_handshake) begin
      r_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_paced_source.sv
// tb/tb_paced_source.sv - directed self-checking bench for paced_source
module tb_paced_source;

  logic clk = 1'b0;
  logic rst;
  logic ovr_a, ovr_b, ovr_c, ovr_d;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dti #(.W(8)) a_in (), a_out (), b_in (), b_out (), c_in (), c_out (), d_in (), d_out ();

  paced_source #(.PERIOD(4), .REPEAT(1'b1), .INIT(64'h0), .INIT_VALID(1'b0)) u_a (
    .clk(clk), .rst(rst), .din(a_in), .dout(a_out), .overrun(ovr_a));
  paced_source #(.PERIOD(4), .REPEAT(1'b0), .INIT(64'h0), .INIT_VALID(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(b_in), .dout(b_out), .overrun(ovr_b));
  paced_source #(.PERIOD(2), .REPEAT(1'b1), .INIT(64'h0), .INIT_VALID(1'b0)) u_c (
    .clk(clk), .rst(rst), .din(c_in), .dout(c_out), .overrun(ovr_c));
  paced_source #(.PERIOD(4), .REPEAT(1'b1), .INIT(64'h3C), .INIT_VALID(1'b1)) u_d (
    .clk(clk), .rst(rst), .din(d_in), .dout(d_out), .overrun(ovr_d));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_in.valid = 1'b0; a_in.data = 8'h00; a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.data = 8'h00; b_out.ready = 1'b1;
    c_in.valid = 1'b0; c_in.data = 8'h00; c_out.ready = 1'b1;
    d_in.valid = 1'b0; d_in.data = 8'h00; d_out.ready = 1'b1;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    // A: PERIOD=4 REPEAT=1, single 0x5A at cycle 1, tokens after ticks 3/7/11
    do_reset();
    #1;
    chk("a_rst_valid", 32'(a_out.valid), 32'd0);
    chk("a_rst_ready", 32'(a_in.ready), 32'd1);
    chk("a_rst_ovr", 32'(ovr_a), 32'd0);
    chk("a_rst_data", 32'(a_out.data), 32'h00);
    next();
    a_in.valid = 1'b1; a_in.data = 8'h5A;
    #1;
    chk("a_c1_valid", 32'(a_out.valid), 32'd0);
    next();
    a_in.valid = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      #1;
      chk($sformatf("a_valid_c%0d", c), 32'(a_out.valid), 32'(c == 4 || c == 8 || c == 12));
      if (c == 4 || c == 8 || c == 12) chk($sformatf("a_data_c%0d", c), 32'(a_out.data), 32'h5A);
      chk($sformatf("a_ovr_c%0d", c), 32'(ovr_a), 32'd0);
      next();
    end

    // B: REPEAT=0, same stimulus, one token only
    do_reset();
    next();
    b_in.valid = 1'b1; b_in.data = 8'h5A;
    next();
    b_in.valid = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      #1;
      chk($sformatf("b_valid_c%0d", c), 32'(b_out.valid), 32'(c == 4));
      if (c == 4) chk("b_data_c4", 32'(b_out.data), 32'h5A);
      chk($sformatf("b_ovr_c%0d", c), 32'(ovr_b), 32'd0);
      next();
    end

    // B2: 0x11 offered exactly in the tick cycle, REPEAT=0
    do_reset();
    next(); next(); next();
    b_in.valid = 1'b1; b_in.data = 8'h11;
    #1;
    chk("b2_c3_ready", 32'(b_in.ready), 32'd1);
    chk("b2_c3_valid", 32'(b_out.valid), 32'd0);
    next();
    b_in.valid = 1'b0;
    #1;
    chk("b2_c4_valid", 32'(b_out.valid), 32'd1);
    chk("b2_c4_data", 32'(b_out.data), 32'h11);
    chk("b2_c4_ready", 32'(b_in.ready), 32'd0);
    next();
    for (int c = 5; c <= 9; c++) begin
      #1;
      chk($sformatf("b2_valid_c%0d", c), 32'(b_out.valid), 32'd0);
      next();
    end

    // C: PERIOD=2, backpressure for 6 cycles after the first token
    do_reset();
    c_in.valid = 1'b1; c_in.data = 8'h77;
    #1;
    chk("c_c0_ready", 32'(c_in.ready), 32'd1);
    next();
    c_in.valid = 1'b0;
    #1;
    chk("c_c1_valid", 32'(c_out.valid), 32'd0);
    chk("c_c1_ovr", 32'(ovr_c), 32'd0);
    next();
    c_out.ready = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      if (c >= 3) begin
        c_in.valid = 1'b1; c_in.data = 8'h99;
      end
      if (c == 8) c_out.ready = 1'b1;
      #1;
      chk($sformatf("c_valid_c%0d", c), 32'(c_out.valid), 32'd1);
      chk($sformatf("c_data_c%0d", c), 32'(c_out.data), 32'h77);
      chk($sformatf("c_ready_c%0d", c), 32'(c_in.ready), 32'd0);
      chk($sformatf("c_ovr_c%0d", c), 32'(ovr_c), 32'(c == 3 || c == 5 || c == 7));
      next();
    end
    #1;
    chk("c_c9_valid", 32'(c_out.valid), 32'd0);
    chk("c_c9_ready", 32'(c_in.ready), 32'd1);
    chk("c_c9_ovr", 32'(ovr_c), 32'd0);
    next();
    c_in.valid = 1'b0;
    #1;
    chk("c_c10_valid", 32'(c_out.valid), 32'd1);
    chk("c_c10_data", 32'(c_out.data), 32'h99);
    next();
    #1;
    chk("c_c11_valid", 32'(c_out.valid), 32'd0);
    next();

    // D: INIT_VALID=1 INIT=0x3C, no input, repeats from first tick
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      #1;
      chk($sformatf("d_valid_c%0d", c), 32'(d_out.valid), 32'(c == 4 || c == 8 || c == 12));
      chk($sformatf("d_data_c%0d", c), 32'(d_out.data), 32'h3C);
      next();
    end

    // E: reset while a token is pending under backpressure
    do_reset();
    a_out.ready = 1'b0;
    a_in.valid = 1'b1; a_in.data = 8'h42;
    next();
    a_in.valid = 1'b0;
    next(); next(); next();
    #1;
    chk("e_c4_valid", 32'(a_out.valid), 32'd1);
    chk("e_c4_data", 32'(a_out.data), 32'h42);
    next();
    #1;
    chk("e_c5_valid", 32'(a_out.valid), 32'd1);
    chk("e_c5_ready", 32'(a_in.ready), 32'd0);
    rst = 1'b1;
    next();
    rst = 1'b0;
    a_out.ready = 1'b1;
    #1;
    chk("e_post_valid", 32'(a_out.valid), 32'd0);
    chk("e_post_ready", 32'(a_in.ready), 32'd1);
    chk("e_post_data", 32'(a_out.data), 32'h00);
    a_in.valid = 1'b1; a_in.data = 8'h24;
    next();
    a_in.valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("e_valid_c%0d", c), 32'(a_out.valid), 32'(c == 4));
      if (c == 4) chk("e_data_c4", 32'(a_out.data), 32'h24);
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
